// File: rtl/lava_multichannel.sv
// LAVA sample selector for time-interleaved channels: emits a sample only when it
// moves far enough from that channel's last emitted value, through a show-ahead FIFO.
module lava_multichannel #(
   parameter int DATA_BITS           = 10,
   parameter int NUM_CHANNELS        = 4,
   parameter int SAMPLES_PER_CHANNEL = 3328,
   parameter int FIFO_DEPTH          = 8,
   localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
   localparam int IDX_W = $clog2(SAMPLES_PER_CHANNEL),
   localparam int OUT_W = CH_W + IDX_W + DATA_BITS
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 clear_i,
   input  logic                 mode_i,
   input  logic [DATA_BITS-1:0] threshold_i,
   input  logic [DATA_BITS-1:0] data_i,
   input  logic                 valid_i,
   output logic                 ready_o,
   output logic [OUT_W-1:0]     data_o,
   output logic                 valid_o,
   input  logic                 ready_i
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CHANNELS - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SAMPLES_PER_CHANNEL - 1);
   localparam logic [CNT_W-1:0] DEPTH    = CNT_W'(FIFO_DEPTH);

   logic [CH_W-1:0]      ch_q;
   logic [IDX_W-1:0]     idx_q;
   logic [DATA_BITS-1:0] ref_q [NUM_CHANNELS];

   logic [OUT_W-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] cnt_q;

   logic [DATA_BITS-1:0] ref_cur;
   logic [DATA_BITS:0]   diff;
   logic [DATA_BITS:0]   mag;
   logic                 hit;
   logic                 beat;
   logic                 emit;
   logic                 pop;

   assign ref_cur = ref_q[ch_q];

   // Signed difference in one extra bit, then magnitude; cannot wrap.
   always_comb begin
      diff = {1'b0, data_i} - {1'b0, ref_cur};
      mag  = diff;
      if (diff[DATA_BITS]) begin
         mag = ~diff + {{DATA_BITS{1'b0}}, 1'b1};
      end
      hit = (mag >= {1'b0, threshold_i});
   end

   assign ready_o = rst_ni & ~clear_i & (cnt_q < DEPTH);
   assign beat    = valid_i & ready_o;
   assign emit    = beat & (mode_i | (idx_q == '0) | hit);
   assign valid_o = (cnt_q != '0);
   assign pop     = valid_o & ready_i;
   assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ch_q  <= '0;
         idx_q <= '0;
      end else if (clear_i) begin
         ch_q  <= '0;
         idx_q <= '0;
      end else if (beat) begin
         if (ch_q == CH_LAST) begin
            ch_q  <= '0;
            idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
         end else begin
            ch_q <= ch_q + CH_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int c = 0; c < NUM_CHANNELS; c++) ref_q[c] <= '0;
      end else if (clear_i) begin
         for (int c = 0; c < NUM_CHANNELS; c++) ref_q[c] <= '0;
      end else if (emit) begin
         ref_q[ch_q] <= data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else if (clear_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (emit) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         cnt_q <= cnt_q + CNT_W'(emit) - CNT_W'(pop);
      end
   end

   // Storage needs no reset: the count alone decides what is visible.
   always_ff @(posedge clk_i) begin
      if (emit) mem_q[wr_ptr_q] <= {ch_q, idx_q, data_i};
   end

endmodule
